// File: rtl/cpu_port_responder.sv
// cpu_port_responder: responder end of the sdram_ctrl CPU port handshake,
// backed by an on-chip 16-bit word RAM with programmable wait states.
// Optional feature macro: CPURESP_LONGWORD_PREFETCH_EN
//   When defined, a longword read/fetch also loads the following word into a
//   prefetch register so that the next sequential read completes without waits.
// INIT_FILE names an optional memory image for flows that preload the RAM
// through their own memory tooling; this RTL never clears or initialises RAM contents.
module cpu_port_responder #(
   parameter int    ADDR_W      = 26,
   parameter int    MEM_BITS    = 12,
   parameter int    WAIT_CYCLES = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic              clk_114,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [3:0]        cpustate,
   input  logic              cpuL,
   input  logic              cpuU,
   input  logic [15:0]       cpuWR,
   output logic [15:0]       cpuRD,
   output logic              cpuena
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   logic [15:0] mem [0:(1<<MEM_BITS)-1];

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                cpuena_q, cpuena_d;
   logic [15:0]         cpurd_q, cpurd_d;
   logic [MEM_BITS-1:0] addr_q, addr_d;
   logic                wr_q, wr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                strb_l_q, strb_l_d;
   logic                strb_u_q, strb_u_d;

   // Access performed on the edge that enters ACK (read into cpuRD or RAM write)
   logic                acc_go;
   logic                acc_wr;
   logic [MEM_BITS-1:0] acc_addr;
   logic [15:0]         acc_wdata;
   logic                acc_l;
   logic                acc_u;

   logic req;
   logic req_write;
   logic unused_inputs;

`ifdef CPURESP_LONGWORD_PREFETCH_EN
   logic                long_q, long_d;
   logic                pf_valid_q, pf_valid_d;
   logic [MEM_BITS-1:0] pf_tag_q, pf_tag_d;
   logic [15:0]         pf_data_q, pf_data_d;
   logic                pf_hit;
   logic [MEM_BITS-1:0] addr_next;

   assign addr_next = addr_q + 1'b1;
   assign pf_hit    = pf_valid_q && !req_write && (cpuAddr[MEM_BITS-1:0] == pf_tag_q);
   assign unused_inputs = ^{cpuAddr[ADDR_W-1:MEM_BITS], (INIT_FILE != "")};
`else
   assign unused_inputs = ^{cpuAddr[ADDR_W-1:MEM_BITS], cpustate[3], (INIT_FILE != "")};
`endif

   // A request is a selected chip (ncs low) with any state other than idle (01)
   assign req       = !cpustate[2] && (cpustate[1:0] != 2'b01);
   assign req_write = (cpustate[1:0] == 2'b11);

   assign cpuena = cpuena_q;
   assign cpuRD  = cpurd_q;

   // Next-state, request latching, access selection and prefetch bookkeeping
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cpuena_d  = 1'b0;
      cpurd_d   = cpurd_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      strb_l_d  = strb_l_q;
      strb_u_d  = strb_u_q;
      acc_go    = 1'b0;
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_l     = strb_l_q;
      acc_u     = strb_u_q;
`ifdef CPURESP_LONGWORD_PREFETCH_EN
      long_d     = long_q;
      pf_valid_d = pf_valid_q;
      pf_tag_d   = pf_tag_q;
      pf_data_d  = pf_data_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d   = cpuAddr[MEM_BITS-1:0];
               wr_d     = req_write;
               wdata_d  = cpuWR;
               strb_l_d = cpuL;
               strb_u_d = cpuU;
`ifdef CPURESP_LONGWORD_PREFETCH_EN
               long_d     = cpustate[3];
               pf_valid_d = 1'b0;
               if (pf_hit) begin
                  state_d  = ST_ACK;
                  cpuena_d = 1'b1;
                  cpurd_d  = pf_data_q;
               end else
`endif
               if (WAIT_CYCLES == 0) begin
                  state_d   = ST_ACK;
                  cpuena_d  = 1'b1;
                  acc_go    = 1'b1;
                  acc_wr    = req_write;
                  acc_addr  = cpuAddr[MEM_BITS-1:0];
                  acc_wdata = cpuWR;
                  acc_l     = cpuL;
                  acc_u     = cpuU;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end

         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d  = ST_ACK;
               cpuena_d = 1'b1;
               acc_go   = 1'b1;
            end
         end

         ST_ACK: begin
            state_d = ST_RELEASE;
`ifdef CPURESP_LONGWORD_PREFETCH_EN
            if (!wr_q && long_q) begin
               pf_valid_d = 1'b1;
               pf_tag_d   = addr_next;
               pf_data_d  = mem[addr_next];
            end
`endif
         end

         ST_RELEASE: begin
            if (!req) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (acc_go && !acc_wr) begin
         cpurd_d = mem[acc_addr];
      end
   end

   // Control and output registers, cleared by synchronous reset
   always_ff @(posedge clk_114) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         cpuena_q <= 1'b0;
         cpurd_q  <= 16'h0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cpuena_q <= cpuena_d;
         cpurd_q  <= cpurd_d;
      end
   end

   // Latched request copy; only meaningful after acceptance, so no reset
   always_ff @(posedge clk_114) begin
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      strb_l_q <= strb_l_d;
      strb_u_q <= strb_u_d;
   end

`ifdef CPURESP_LONGWORD_PREFETCH_EN
   // Prefetch state: the valid flag is control and resets, tag/data do not
   always_ff @(posedge clk_114) begin
      if (reset) begin
         pf_valid_q <= 1'b0;
      end else begin
         pf_valid_q <= pf_valid_d;
      end
      long_q    <= long_d;
      pf_tag_q  <= pf_tag_d;
      pf_data_q <= pf_data_d;
   end
`endif

   // Byte-lane RAM write; reset suppresses a write on the edge that would enter ACK
   always_ff @(posedge clk_114) begin
      if (!reset && acc_go && acc_wr) begin
         if (!acc_l) begin
            mem[acc_addr][7:0] <= acc_wdata[7:0];
         end
         if (!acc_u) begin
            mem[acc_addr][15:8] <= acc_wdata[15:8];
         end
      end
   end

endmodule

// File: tb/tb_cpu_port_responder.sv
// Bench for cpu_port_responder: driver pushes expected completions into a
// scoreboard, a negedge monitor pops and compares each cpuena pulse.
// Honors CPURESP_LONGWORD_PREFETCH_EN for the expected latency of hits.
module tb_cpu_port_responder;

   localparam int ADDR_W      = 26;
   localparam int MEM_BITS    = 12;
   localparam int WAIT_CYCLES = 2;
   localparam int DEPTH       = 1 << MEM_BITS;
`ifdef CPURESP_LONGWORD_PREFETCH_EN
   localparam bit PF_EN = 1'b1;
`else
   localparam bit PF_EN = 1'b0;
`endif

   localparam logic [3:0] ST_WR   = 4'b0011;
   localparam logic [3:0] ST_RD   = 4'b0010;
   localparam logic [3:0] ST_FT   = 4'b0000;
   localparam logic [3:0] ST_LRD  = 4'b1010;
   localparam logic [3:0] ST_NONE = 4'b0101;

   logic              clk_114 = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] cpuAddr;
   logic [3:0]        cpustate;
   logic              cpuL;
   logic              cpuU;
   logic [15:0]       cpuWR;
   logic [15:0]       cpuRD;
   logic              cpuena;

   cpu_port_responder #(
      .ADDR_W(ADDR_W), .MEM_BITS(MEM_BITS), .WAIT_CYCLES(WAIT_CYCLES), .INIT_FILE("")
   ) dut (
      .clk_114(clk_114), .reset(reset), .cpuAddr(cpuAddr), .cpustate(cpustate),
      .cpuL(cpuL), .cpuU(cpuU), .cpuWR(cpuWR), .cpuRD(cpuRD), .cpuena(cpuena)
   );

   always #5 clk_114 = ~clk_114;

   int cyc = 0;
   always @(posedge clk_114) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // Scoreboard: expected completion cycle, expected cpuRD, label
   int          q_cyc [$];
   logic [15:0] q_dat [$];
   string       q_nm  [$];

   // Reference model: word memory, last read value, prefetch tag
   logic [15:0] ref_mem [DEPTH];
   logic [15:0] ref_rd;
   bit          pf_v;
   int          pf_tag;
   logic [15:0] obs_rd;

   task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every cpuena pulse must match the oldest outstanding expectation
   always @(negedge clk_114) begin
      if (cpuena !== 1'b0) begin
         pulses++;
         if (q_cyc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_cpuena: got pulse at cycle %0d expected none", cyc);
         end else begin
            check_int({q_nm[0], "_cycle"}, cyc, q_cyc[0]);
            check16({q_nm[0], "_rd"}, cpuRD, q_dat[0]);
            obs_rd = cpuRD;
            void'(q_cyc.pop_front());
            void'(q_dat.pop_front());
            void'(q_nm.pop_front());
         end
      end
   end

   task automatic drive_idle();
      cpustate = ST_NONE;
   endtask

   // One access, called just after a negedge with the DUT idle.
   task automatic access(input logic [ADDR_W-1:0] a, input logic [3:0] st, input logic l,
                         input logic u, input logic [15:0] wd, input int hold, input int gap,
                         input string nm);
      int ia;
      bit is_wr;
      bit hit;
      int lat;
      int n;
      ia    = int'(a[MEM_BITS-1:0]);
      is_wr = (st[1:0] == 2'b11);
      hit   = PF_EN && !is_wr && pf_v && (ia == pf_tag);
      lat   = hit ? 0 : WAIT_CYCLES;
      if (is_wr) begin
         if (!l) ref_mem[ia][7:0] = wd[7:0];
         if (!u) ref_mem[ia][15:8] = wd[15:8];
      end else begin
         ref_rd = ref_mem[ia];
      end
      q_cyc.push_back(cyc + 1 + lat);
      q_dat.push_back(ref_rd);
      q_nm.push_back(nm);
      pf_v = !is_wr && st[3];
      pf_tag = (ia + 1) % DEPTH;
      cpuAddr = a; cpustate = st; cpuL = l; cpuU = u; cpuWR = wd;
      n = 0;
      do begin
         @(negedge clk_114);
         n++;
      end while (cpuena !== 1'b1 && n < 40);
      if (cpuena !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no cpuena in %0d cycles expected a pulse", nm, n);
      end
      repeat (hold) @(negedge clk_114);
      drive_idle();
      repeat (gap) @(negedge clk_114);
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      drive_idle();
      repeat (n) @(negedge clk_114);
      reset  = 1'b0;
      ref_rd = 16'h0000;
      pf_v   = 1'b0;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom);
      if ($urandom_range(0, 1) == 1) a[MEM_BITS-1:0] = MEM_BITS'($urandom_range(0, 63));
      else a[MEM_BITS-1:0] = MEM_BITS'($urandom_range(DEPTH - 64, DEPTH - 1));
      return a;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by cycle %0d expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] last_lw;
      logic [3:0]        st;
      int                p0;
      int                hold;
      bit                have_lw;

      reset = 1'b1; cpuAddr = '0; cpustate = ST_NONE; cpuL = 1'b1; cpuU = 1'b1; cpuWR = '0;
      ref_rd = 16'h0000; pf_v = 1'b0; pf_tag = 0; obs_rd = 16'h0000;
      repeat (3) @(negedge clk_114);
      check16("reset_cpuena", {15'd0, cpuena}, 16'h0000);
      check16("reset_cpurd", cpuRD, 16'h0000);
      reset = 1'b0;
      @(negedge clk_114);

      // Known contents for both ends of the address space
      for (int i = 0; i < 64; i++) begin
         access(ADDR_W'(i), ST_WR, 1'b0, 1'b0, 16'($urandom), 0, 2, "fill_lo");
         access(ADDR_W'(DEPTH - 64 + i), ST_WR, 1'b0, 1'b0, 16'($urandom), 0, 2, "fill_hi");
      end

      // Full write then read back
      access(26'h010, ST_WR, 1'b0, 1'b0, 16'hBEEF, 0, 2, "t1_wr");
      access(26'h010, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t1_rd");
      check16("t1_value", obs_rd, 16'hBEEF);

      // Byte lanes, and a write with both strobes inactive
      access(26'h010, ST_WR, 1'b1, 1'b0, 16'h12AA, 0, 2, "t2_wr_hi");
      access(26'h010, ST_FT, 1'b1, 1'b1, 16'h0000, 0, 2, "t2_rd1");
      check16("t2_value1", obs_rd, 16'h12EF);
      access(26'h010, ST_WR, 1'b1, 1'b1, 16'h0000, 0, 2, "t2_wr_none");
      access(26'h010, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t2_rd2");
      check16("t2_value2", obs_rd, 16'h12EF);

      // Held request is serviced once; one idle clock allows the next
      p0 = pulses;
      access(26'h010, ST_RD, 1'b1, 1'b1, 16'h0000, 20, 1, "t3_first");
      check_int("t3_pulses_held", pulses - p0, 1);
      access(26'h010, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t3_second");
      check_int("t3_pulses_total", pulses - p0, 2);

      // Reset during WAIT of a write aborts it
      cpuAddr = 26'h020; cpustate = ST_WR; cpuL = 1'b0; cpuU = 1'b0; cpuWR = 16'h5555;
      @(negedge clk_114);
      apply_reset(2);
      check16("t4_rd_after_reset", cpuRD, 16'h0000);
      check16("t4_ena_after_reset", {15'd0, cpuena}, 16'h0000);
      @(negedge clk_114);
      access(26'h020, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t4_rd_prior");
      check16("t4_prior_value", obs_rd, ref_mem[32]);

      // Address aliasing and no carry out of the decoded field
      access(26'h1010, ST_WR, 1'b0, 1'b0, 16'hCAFE, 0, 2, "t5_wr_alias");
      access(26'h0010, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t5_rd_alias");
      check16("t5_alias_value", obs_rd, 16'hCAFE);
      access(26'h0FFF, ST_WR, 1'b0, 1'b0, 16'h7777, 0, 2, "t5_wr_top");
      access(26'h0000, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t5_rd_zero");

      // Longword read followed by the sequential word
      access(26'h030, ST_WR, 1'b0, 1'b0, 16'h1111, 0, 2, "t6_wr0");
      access(26'h031, ST_WR, 1'b0, 1'b0, 16'h2222, 0, 2, "t6_wr1");
      access(26'h030, ST_LRD, 1'b1, 1'b1, 16'h0000, 0, 2, "t6_lrd");
      access(26'h031, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t6_next");
      check16("t6_next_value", obs_rd, 16'h2222);

      // Reset and writes both invalidate a pending prefetch
      access(26'h040, ST_LRD, 1'b1, 1'b1, 16'h0000, 0, 2, "t7_lrd");
      apply_reset(2);
      @(negedge clk_114);
      access(26'h041, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t7_after_reset");
      access(26'h050, ST_LRD, 1'b1, 1'b1, 16'h0000, 0, 2, "t7_lrd2");
      access(26'h051, ST_WR, 1'b0, 1'b0, 16'hA5C3, 0, 2, "t7_wr");
      access(26'h051, ST_RD, 1'b1, 1'b1, 16'h0000, 0, 2, "t7_rd_new");
      check16("t7_new_value", obs_rd, 16'hA5C3);

      // Prefetch tag wraps from the top word to word zero
      access(26'h0FFF, ST_LRD, 1'b1, 1'b1, 16'h0000, 0, 2, "t8_lrd_top");
      access(26'h2000, ST_FT, 1'b1, 1'b1, 16'h0000, 0, 2, "t8_wrap");

      // Randomized traffic against the model
      have_lw = 1'b0;
      last_lw = '0;
      for (int k = 0; k < 150; k++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         hold = int'($urandom_range(0, 3));
         if (kind == 0) begin
            cpuAddr = rand_addr(); cpuWR = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
               cpustate = {1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3))};
            else
               cpustate = {1'($urandom_range(0, 1)), 1'b0, 2'b01};
            repeat (3) @(negedge clk_114);
            drive_idle();
         end else if (kind <= 3) begin
            access(rand_addr(), ST_WR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), hold, (hold > 0) ? 1 : 2, "rnd_wr");
            have_lw = 1'b0;
         end else begin
            st = ($urandom_range(0, 1) == 1) ? ST_RD : ST_FT;
            st[3] = 1'($urandom_range(0, 1));
            if (have_lw && $urandom_range(0, 2) != 0) begin
               a = ADDR_W'($urandom);
               a[MEM_BITS-1:0] = last_lw[MEM_BITS-1:0] + 1'b1;
            end else begin
               a = rand_addr();
            end
            access(a, st, 1'b1, 1'b1, 16'h0000, hold, (hold > 0) ? 1 : 2, "rnd_rd");
            have_lw = st[3];
            last_lw = a;
         end
      end

      repeat (5) @(negedge clk_114);
      check_int("pending_at_end", q_cyc.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
